vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16: video RAM address width.
REQ-002 Parameter DATA_W, default 8: video RAM data width, one RGB332 pixel.
REQ-003 Parameter MAX_WAIT, default 4: consecutive display wins tolerated before the CPU is forced a grant (guard builds only).
REQ-004 clk  input  1  system clock, 100 MHz.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 disp_req  input  1  display scanout read request, level, held until disp_valid.
REQ-007 disp_addr  input  ADDR_W  display read address, stable while disp_req is high.
REQ-008 disp_data  output  DATA_W  display read data.
REQ-009 disp_valid  output  1  display read complete, one-cycle pulse.
REQ-010 cpu_req  input  1  CPU access request, level, held until cpu_ack.
REQ-011 cpu_we  input  1  CPU write (1) or read (0), stable while cpu_req is high.
REQ-012 cpu_addr  input  ADDR_W  CPU address, stable while cpu_req is high.
REQ-013 cpu_wdata  input  DATA_W  CPU write data, stable while cpu_req is high.
REQ-014 cpu_rdata  output  DATA_W  CPU read data.
REQ-015 cpu_ack  output  1  CPU access complete, one-cycle pulse, for reads and writes.
REQ-016 mem_en  output  1  RAM access enable, registered.
REQ-017 mem_we  output  1  RAM write enable, registered.
REQ-018 mem_addr  output  ADDR_W  RAM address, registered.
REQ-019 mem_wdata  output  DATA_W  RAM write data, registered.
REQ-020 mem_rdata  input  DATA_W  RAM read data, valid exactly one cycle after an enabled read.
REQ-021 busy  output  1  high whenever state is not IDLE.

Function
REQ-022 FSM states: IDLE, ACCESS, RESP; IDLE->ACCESS on grant, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-023 IDLE: disp_req high -> grant DISP; else cpu_req high -> grant CPU; neither -> remain IDLE.
REQ-024 On grant, the owner, address, we and wdata are registered; mem_en=1, mem_we=(owner CPU and cpu_we), mem_addr, mem_wdata are driven during ACCESS only.
REQ-025 mem_en=0 and mem_we=0 in IDLE and RESP; mem_addr and mem_wdata hold their last values.
REQ-026 RESP: owner DISP -> disp_valid=1 and disp_data=mem_rdata; owner CPU -> cpu_ack=1 and cpu_rdata=mem_rdata (value don't-care on writes).
REQ-027 disp_data and cpu_rdata are 0 whenever their ack/valid is low.
REQ-028 Latency: request sampled in IDLE cycle T -> mem_en at T+1 -> ack/valid at T+2; next grant no earlier than T+3; one access per 3 cycles maximum.
REQ-029 Requests are not re-sampled in ACCESS or RESP; requesters deassert in the cycle after their ack, so no double grant occurs.
REQ-030 Simultaneous disp_req and cpu_req in IDLE -> DISP wins, except as overridden by REQ-034.

Reset
REQ-031 rst high at a clock edge -> state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, disp_valid=0, cpu_ack=0, busy=0, wait counter=0, from the next cycle.
REQ-032 rst during ACCESS or RESP aborts the transaction: no ack or valid is issued for it; the requester re-presents its request after reset.

Configuration
REQ-033 Macro VRAM_ARB_STARVE_GUARD_EN compiles in a CPU starvation guard.
REQ-034 With the macro: a wait counter, width clog2(MAX_WAIT+1), increments, saturating at MAX_WAIT, on each DISP grant made while cpu_req is high, and clears on each CPU grant; in IDLE, cpu_req high with counter==MAX_WAIT -> CPU granted regardless of disp_req.
REQ-035 Without the macro: no counter exists, and strict display priority applies always.

Verification
REQ-036 Single display read: disp_req=1, disp_addr=0x1234 at T, RAM holds 0xA5 -> mem_en=1, mem_addr=0x1234 at T+1; disp_valid=1, disp_data=0xA5 at T+2.
REQ-037 CPU write: cpu_we=1, cpu_addr=0x0042, cpu_wdata=0x3C -> mem_we=1 at T+1, cpu_ack at T+2; a subsequent CPU read of 0x0042 returns 0x3C.
REQ-038 Simultaneous display and CPU requests in IDLE -> display acked at T+2, CPU mem_en at T+4, cpu_ack at T+5.
REQ-039 Guard build, MAX_WAIT=4, disp_req and cpu_req held continuously -> 4 display grants, then 1 CPU grant, repeating; non-guard build -> cpu_ack never asserts.
REQ-040 rst pulsed during ACCESS of a CPU write -> no cpu_ack, mem_en=0 the cycle after reset, busy=0, and the next request is served normally.

Source files
------------

// File: rtl/vram_arbiter.sv
// Video RAM arbiter: one shared single-port RAM between display scanout (priority) and CPU.
// Optional CPU starvation guard compiled in with VRAM_ARB_STARVE_GUARD_EN.
module vram_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic                owner_cpu_r;
  logic                mem_en_r;
  logic                mem_we_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic                disp_valid_r;
  logic                cpu_ack_r;
  logic                busy_r;
  logic                force_cpu_s;
  logic                grant_disp_s;
  logic                grant_cpu_s;

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_r;

  assign force_cpu_s = cpu_req && (wait_cnt_r == WAIT_MAX);

  // Count display wins over a waiting CPU; any CPU grant clears the count
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (grant_cpu_s) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (grant_disp_s && cpu_req && (wait_cnt_r != WAIT_MAX)) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end
  end
`else
  assign force_cpu_s = 1'b0;
`endif

  // Grant decision; only IDLE samples requests
  always_comb begin
    grant_disp_s = 1'b0;
    grant_cpu_s  = 1'b0;
    if (state_r == IDLE) begin
      if (force_cpu_s) begin
        grant_cpu_s = 1'b1;
      end else if (disp_req) begin
        grant_disp_s = 1'b1;
      end else if (cpu_req) begin
        grant_cpu_s = 1'b1;
      end else begin
        grant_disp_s = 1'b0;
        grant_cpu_s  = 1'b0;
      end
    end else begin
      grant_disp_s = 1'b0;
      grant_cpu_s  = 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_disp_s || grant_cpu_s) begin
          state_next_s = ACCESS;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCESS:  state_next_s = RESP;
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Memory port, owner capture and response strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_cpu_r  <= 1'b0;
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {DATA_W{1'b0}};
      disp_valid_r <= 1'b0;
      cpu_ack_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      busy_r <= (state_next_s != IDLE);
      case (state_r)
        IDLE: begin
          disp_valid_r <= 1'b0;
          cpu_ack_r    <= 1'b0;
          if (grant_disp_s || grant_cpu_s) begin
            owner_cpu_r <= grant_cpu_s;
            mem_en_r    <= 1'b1;
            mem_we_r    <= grant_cpu_s & cpu_we;
            mem_addr_r  <= grant_cpu_s ? cpu_addr : disp_addr;
            // Display grants leave the write-data register untouched
            if (grant_cpu_s) begin
              mem_wdata_r <= cpu_wdata;
            end
          end else begin
            mem_en_r <= 1'b0;
            mem_we_r <= 1'b0;
          end
        end
        ACCESS: begin
          mem_en_r     <= 1'b0;
          mem_we_r     <= 1'b0;
          disp_valid_r <= ~owner_cpu_r;
          cpu_ack_r    <= owner_cpu_r;
        end
        RESP: begin
          mem_en_r     <= 1'b0;
          mem_we_r     <= 1'b0;
          disp_valid_r <= 1'b0;
          cpu_ack_r    <= 1'b0;
        end
        default: begin
          mem_en_r     <= 1'b0;
          mem_we_r     <= 1'b0;
          disp_valid_r <= 1'b0;
          cpu_ack_r    <= 1'b0;
        end
      endcase
    end
  end

  // Read data arrives from the RAM during RESP, so it is steered, not re-registered
  assign disp_data  = disp_valid_r ? mem_rdata : {DATA_W{1'b0}};
  assign cpu_rdata  = cpu_ack_r    ? mem_rdata : {DATA_W{1'b0}};
  assign disp_valid = disp_valid_r;
  assign cpu_ack    = cpu_ack_r;
  assign mem_en     = mem_en_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: requesters push expected responses, a monitor pops on valid/ack.
// Expected read data comes from a shadow of written bytes over a fixed RAM fill pattern.
module tb_vram_arbiter;

  logic        clk;
  logic        rst;
  logic        disp_req;
  logic [15:0] disp_addr;
  logic [7:0]  disp_data;
  logic        disp_valid;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;

  vram_arbiter dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct packed {
    logic       rd;
    logic [7:0] d;
  } cexp_t;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  dq[$];
  cexp_t       cq[$];
  logic [7:0]  model_wr[logic [15:0]];
  logic [7:0]  ram [0:255];
  logic        ram_load;
  logic        free_run;
  logic [15:0] free_daddr;
  logic [15:0] free_caddr;
  logic        tr_en   [1:8];
  logic        tr_we   [1:8];
  logic        tr_busy [1:8];
  logic [15:0] tr_addr [1:8];
  logic [7:0]  tr_wd   [1:8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_pat(input logic [7:0] a);
    return a ^ 8'h91;
  endfunction

  function automatic logic [7:0] exp_rd(input logic [15:0] a);
    if (model_wr.exists(a)) return model_wr[a];
    return init_pat(a[7:0]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // RAM model: read data valid exactly one cycle after an enabled read, garbage otherwise
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_pat(8'(i));
      mem_rdata <= 8'h00;
    end else if (mem_en && mem_we) begin
      ram[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= 8'($urandom);
    end else if (mem_en) begin
      mem_rdata <= ram[mem_addr[7:0]];
    end else begin
      mem_rdata <= 8'($urandom);
    end
  end

  // Monitor / scoreboard
  initial begin
    cexp_t ce;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (disp_valid) begin
          if (free_run) chk("disp_data_free", 32'(disp_data), 32'(exp_rd(free_daddr)));
          else if (dq.size() == 0) chk("disp_valid_spurious", 32'(disp_valid), 32'd0);
          else chk("disp_data", 32'(disp_data), 32'(dq.pop_front()));
        end else begin
          chk("disp_data_quiet", 32'(disp_data), 32'd0);
        end
        if (cpu_ack) begin
          if (free_run) chk("cpu_rdata_free", 32'(cpu_rdata), 32'(exp_rd(free_caddr)));
          else if (cq.size() == 0) chk("cpu_ack_spurious", 32'(cpu_ack), 32'd0);
          else begin
            ce = cq.pop_front();
            if (ce.rd) chk("cpu_rdata", 32'(cpu_rdata), 32'(ce.d));
            else chk("cpu_wr_ack", 32'(cpu_ack), 32'd1);
          end
        end else begin
          chk("cpu_rdata_quiet", 32'(cpu_rdata), 32'd0);
        end
      end
    end
  end

  // Issue a display and/or CPU request together; return cycles until each completion
  task automatic run_pair(input bit do_d, input logic [15:0] da, input bit do_c, input bit cwe,
                          input logic [15:0] ca, input logic [7:0] cwd,
                          output int d_lat, output int c_lat);
    bit d_pend;
    bit c_pend;
    @(negedge clk);
    d_lat = 0;
    c_lat = 0;
    d_pend = do_d;
    c_pend = do_c;
    if (do_d) begin
      disp_req = 1'b1; disp_addr = da;
      dq.push_back(exp_rd(da));
    end
    if (do_c) begin
      cpu_req = 1'b1; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
      cq.push_back('{rd: ~cwe, d: exp_rd(ca)});
      if (cwe) model_wr[ca] = cwd;
    end
    for (int i = 1; i <= 20 && (d_pend || c_pend); i++) begin
      @(negedge clk);
      if (i <= 8) begin
        tr_en[i] = mem_en; tr_we[i] = mem_we; tr_busy[i] = busy;
        tr_addr[i] = mem_addr; tr_wd[i] = mem_wdata;
      end
      if (d_pend && disp_valid) begin d_lat = i; d_pend = 1'b0; disp_req = 1'b0; end
      if (c_pend && cpu_ack) begin c_lat = i; c_pend = 1'b0; cpu_req = 1'b0; end
    end
    if (d_pend) begin disp_req = 1'b0; dq.delete(); end
    if (c_pend) begin cpu_req = 1'b0; cq.delete(); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int dl, cl, op, nd, nc;
    logic [15:0] a1, a2;
    logic [7:0] wd;
    logic [9:0] seq;
    bit we;
    rst = 1'b1; ram_load = 1'b1; free_run = 1'b0;
    disp_req = 1'b0; disp_addr = 16'h0000;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    free_daddr = 16'h0060; free_caddr = 16'h0070;
    repeat (3) @(negedge clk);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_disp_valid", 32'(disp_valid), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0; ram_load = 1'b0;

    // Single display read of 0x1234 (RAM fill gives 0xA5)
    run_pair(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 8'h00, dl, cl);
    chk("d1_mem_en", 32'(tr_en[1]), 32'd1);
    chk("d1_mem_addr", 32'(tr_addr[1]), 32'h1234);
    chk("d1_mem_we", 32'(tr_we[1]), 32'd0);
    chk("d1_busy", 32'(tr_busy[1]), 32'd1);
    chk("d1_mem_en_resp", 32'(tr_en[2]), 32'd0);
    chk("d1_lat", 32'(dl), 32'd2);
    @(negedge clk);
    chk("d1_idle_busy", 32'(busy), 32'd0);

    // CPU write then read-back
    run_pair(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0042, 8'h3C, dl, cl);
    chk("w1_mem_we", 32'(tr_we[1]), 32'd1);
    chk("w1_mem_addr", 32'(tr_addr[1]), 32'h0042);
    chk("w1_mem_wdata", 32'(tr_wd[1]), 32'h3C);
    chk("w1_lat", 32'(cl), 32'd2);
    run_pair(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0042, 8'h00, dl, cl);
    chk("r1_mem_we", 32'(tr_we[1]), 32'd0);
    chk("r1_lat", 32'(cl), 32'd2);

    // Simultaneous requests: display first, CPU three cycles later
    run_pair(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0011, 8'h00, dl, cl);
    chk("p1_disp_lat", 32'(dl), 32'd2);
    chk("p1_cpu_lat", 32'(cl), 32'd5);
    chk("p1_addr1", 32'(tr_addr[1]), 32'h0010);
    chk("p1_en3", 32'(tr_en[3]), 32'd0);
    chk("p1_en4", 32'(tr_en[4]), 32'd1);
    chk("p1_addr4", 32'(tr_addr[4]), 32'h0011);

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      op = int'($urandom_range(0, 3));
      a1 = 16'($urandom_range(0, 31));
      a2 = 16'($urandom_range(0, 31));
      wd = 8'($urandom);
      we = 1'($urandom_range(0, 1));
      case (op)
        0: begin run_pair(1'b1, a1, 1'b0, 1'b0, 16'h0000, 8'h00, dl, cl); chk("rnd_disp_lat", 32'(dl), 32'd2); end
        1: begin run_pair(1'b0, 16'h0000, 1'b1, 1'b0, a2, 8'h00, dl, cl); chk("rnd_cpu_rd_lat", 32'(cl), 32'd2); end
        2: begin run_pair(1'b0, 16'h0000, 1'b1, 1'b1, a2, wd, dl, cl); chk("rnd_cpu_wr_lat", 32'(cl), 32'd2); end
        default: begin
          run_pair(1'b1, a1, 1'b1, we, a2, wd, dl, cl);
          chk("rnd_pair_disp_lat", 32'(dl), 32'd2);
          chk("rnd_pair_cpu_lat", 32'(cl), 32'd5);
        end
      endcase
    end

    // Reset during ACCESS of a CPU write aborts it
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0F80; cpu_wdata = 8'h77;
    @(negedge clk);
    chk("abort_access_we", 32'(mem_we), 32'd1);
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_mem_en", 32'(mem_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("abort_mem_addr", 32'(mem_addr), 32'd0);
    model_wr[16'h0F80] = 8'h77;
    nc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cpu_ack) nc++;
    end
    chk("abort_no_late_ack", 32'(nc), 32'd0);
    run_pair(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0F80, 8'h5E, dl, cl);
    chk("after_abort_wr_lat", 32'(cl), 32'd2);
    run_pair(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0F80, 8'h00, dl, cl);
    chk("after_abort_rd_lat", 32'(cl), 32'd2);

    // Both requesters held continuously from a fresh reset
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    free_run = 1'b1;
    disp_req = 1'b1; disp_addr = free_daddr;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = free_caddr;
    nd = 0; nc = 0; seq = 10'd0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (disp_valid) begin nd++; seq = {seq[8:0], 1'b0}; end
      if (cpu_ack) begin nc++; seq = {seq[8:0], 1'b1}; end
      if (i == 30) begin disp_req = 1'b0; cpu_req = 1'b0; end
    end
    @(negedge clk);
    free_run = 1'b0;
    chk("starve_events", 32'(nd + nc), 32'd10);
`ifdef VRAM_ARB_STARVE_GUARD_EN
    chk("starve_pattern", 32'(seq), 32'(10'b0000100001));
`else
    chk("starve_cpu_acks", 32'(nc), 32'd0);
    chk("starve_disp_grants", 32'(nd), 32'd10);
`endif
    repeat (3) @(negedge clk);
    chk("end_dq_empty", 32'(dq.size()), 32'd0);
    chk("end_cq_empty", 32'(cq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
